// File: rtl/usrxround.sv
// rtl/usrxround.sv - multi-receiver sample round packer into a 24-bit FWFT FIFO
// Optional drop accounting (overrun_cnt, us_tuser[1]) is enabled by USRXROUND_OVERRUN_EN.
module usrxround #(
  parameter int NRX = 12,
  parameter int AW  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [5:0]       cmd_addr,
  input  logic [31:0]      cmd_data,
  input  logic             cmd_rqst,
  input  logic [NRX*48-1:0] rx_tdata,
  input  logic             rx_tvalid,
  input  logic             mic_bit,
  output logic [23:0]      us_tdata,
  output logic             us_tlast,
  output logic [1:0]       us_tuser,
  output logic             us_tvalid,
  input  logic             us_tready,
  output logic [10:0]      us_tlength,
  output logic [15:0]      overrun_cnt
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {IDLE, WRITE} state_t;
  state_t state, state_nxt;

  logic [4:0]         nrx_cfg, cfg_req, widx, last_idx;
  logic [NRX*48-1:0]  samp;
  logic               mic_q, flag_q;
  logic               accept, wr_en, pop, fits, is_last;
  logic [23:0]        word_data;
  logic [26:0]        wr_word, head;
  logic [26:0]        mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic [AW+1:0]      fill_after;
  logic               unused_ok;

  assign unused_ok = ^{cmd_data[31:7], cmd_data[2:0]};

  assign cfg_req = {1'b0, cmd_data[6:3]} + 5'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      nrx_cfg <= 5'd1;
    else if (cmd_rqst && cmd_addr == 6'h00)
      nrx_cfg <= (cfg_req > 5'(NRX)) ? 5'(NRX) : cfg_req;
  end

  // A round is admitted only if every one of its words is guaranteed a slot.
  assign fill_after = {1'b0, count} + (AW+2)'({nrx_cfg, 1'b0});
  assign fits       = fill_after <= (AW+2)'(DEPTH);
  assign is_last    = (widx == last_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    wr_en     = 1'b0;
    case (state)
      IDLE: begin
        if (run && rx_tvalid && fits) begin
          accept    = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (!run) begin
          state_nxt = IDLE;
        end else begin
          wr_en = 1'b1;
          if (is_last) state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp     <= '0;
      mic_q    <= 1'b0;
      widx     <= '0;
      last_idx <= '0;
    end else if (accept) begin
      samp     <= rx_tdata;
      mic_q    <= mic_bit;
      widx     <= '0;
      last_idx <= {nrx_cfg[3:0], 1'b0} - 5'd1;
    end else if (wr_en) begin
      widx     <= widx + 5'd1;
    end
  end

  // Even word index selects I (upper half of the receiver slot), odd selects Q.
  always_comb begin
    word_data = '0;
    for (int r = 0; r < NRX; r++) begin
      if (widx[4:1] == 4'(r))
        word_data = widx[0] ? samp[r*48 +: 24] : samp[r*48+24 +: 24];
    end
  end

  assign wr_word = {flag_q & (widx == 5'd0), mic_q, is_last, word_data};

`ifdef USRXROUND_OVERRUN_EN
  logic        drop, pend;
  logic [15:0] ovr_q;

  assign drop = run && rx_tvalid && ((state == IDLE && !fits) || state == WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q  <= '0;
      pend   <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      if (drop) begin
        if (ovr_q != 16'hFFFF) ovr_q <= ovr_q + 16'd1;
        pend <= 1'b1;
      end
      if (accept) begin
        flag_q <= pend;
        pend   <= 1'b0;
      end
    end
  end

  assign overrun_cnt = ovr_q;
`else
  assign flag_q      = 1'b0;
  assign overrun_cnt = '0;
`endif

  assign pop = (count != '0) && us_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (!run) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_word;
  end

  // Head outputs are gated so stale RAM contents never show while empty.
  assign head       = mem[rd_ptr];
  assign us_tvalid  = (count != '0);
  assign us_tdata   = us_tvalid ? head[23:0]  : '0;
  assign us_tlast   = us_tvalid ? head[24]    : 1'b0;
  assign us_tuser   = us_tvalid ? head[26:25] : 2'b00;
  assign us_tlength = 11'(count);

endmodule

// File: tb/tb_usrxround.sv
// tb/tb_usrxround.sv - scoreboard bench for usrxround
module tb_usrxround;
  localparam int NRX = 12;
  localparam int AW  = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              run = 1'b0;
  logic [5:0]        cmd_addr = '0;
  logic [31:0]       cmd_data = '0;
  logic              cmd_rqst = 1'b0;
  logic [NRX*48-1:0] rx_tdata = '0;
  logic              rx_tvalid = 1'b0;
  logic              mic_bit = 1'b0;
  logic [23:0]       us_tdata;
  logic              us_tlast;
  logic [1:0]        us_tuser;
  logic              us_tvalid;
  logic              us_tready = 1'b0;
  logic [10:0]       us_tlength;
  logic [15:0]       overrun_cnt;

  usrxround #(.NRX(NRX), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_rqst(cmd_rqst),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .mic_bit(mic_bit),
    .us_tdata(us_tdata), .us_tlast(us_tlast), .us_tuser(us_tuser),
    .us_tvalid(us_tvalid), .us_tready(us_tready),
    .us_tlength(us_tlength), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [26:0] sb [$];
  int          cur_nrx = 1;
  bit          pend_m = 1'b0;
  int          ovr_m = 0;
  int          max_len = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && int'(us_tlength) > max_len) max_len = int'(us_tlength);
    if (rst_n && run && us_tvalid && us_tready) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0)
        check("word", 32'({us_tuser, us_tlast, us_tdata}), 32'(sb.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [5:0] addr, input logic [3:0] f);
    cmd_addr = addr;
    cmd_data = {25'h1ABCDE0, f, 3'b101};
    cmd_rqst = 1'b1;
    tick(1);
    cmd_rqst = 1'b0;
    if (addr == 6'h00) cur_nrx = (int'(f) + 1 > NRX) ? NRX : int'(f) + 1;
  endtask

  task automatic send_round(input bit fixed, input bit acc);
    logic [23:0] iv, qv;
    for (int r = 0; r < NRX; r++) begin
      iv = fixed ? 24'(2*r + 1) : 24'($urandom);
      qv = fixed ? 24'(2*r + 2) : 24'($urandom);
      rx_tdata[r*48 +: 48] = {iv, qv};
    end
    mic_bit   = 1'($urandom);
    rx_tvalid = 1'b1;
    if (acc) begin
      for (int r = 0; r < cur_nrx; r++) begin
        sb.push_back({(r == 0) ? pend_m : 1'b0, mic_bit, 1'b0, rx_tdata[r*48+24 +: 24]});
        sb.push_back({1'b0, mic_bit, (r == cur_nrx - 1), rx_tdata[r*48 +: 24]});
      end
      pend_m = 1'b0;
    end else begin
`ifdef USRXROUND_OVERRUN_EN
      pend_m = 1'b1;
      if (ovr_m < 65535) ovr_m++;
`endif
    end
    tick(1);
    rx_tvalid = 1'b0;
  endtask

  task automatic wait_len(input string tag, input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (int'(us_tlength) == target) break;
      tick(1);
    end
    check(tag, 32'(us_tlength), 32'(target));
  endtask

  initial begin
    tick(2);
    check("rst_tvalid", 32'(us_tvalid), 32'd0);
    check("rst_tlength", 32'(us_tlength), 32'd0);
    check("rst_tdata", 32'(us_tdata), 32'd0);
    check("rst_ovr", 32'(overrun_cnt), 32'd0);
    rst_n = 1'b1;
    run   = 1'b1;
    tick(2);

    // two receivers, fixed pattern; non-zero address must not change the config
    set_cfg(6'h00, 4'd1);
    set_cfg(6'h05, 4'd11);
    send_round(1'b1, 1'b1);
    wait_len("len_two_rx", 4, 20);
    check("head_first", 32'(us_tdata), 32'h000001);
    us_tready = 1'b1;
    wait_len("drain_two_rx", 0, 40);
    us_tready = 1'b0;

    // single receiver streaming with steady ready
    set_cfg(6'h00, 4'd0);
    us_tready = 1'b1;
    max_len = 0;
    repeat (5) begin
      send_round(1'b0, 1'b1);
      tick(9);
    end
    check("max_len_le2", 32'(max_len <= 2), 32'd1);
    us_tready = 1'b0;

    // strobe during WRITE drops the second round
    set_cfg(6'h00, 4'd3);
    send_round(1'b0, 1'b1);
    tick(2);
    send_round(1'b0, 1'b0);
    wait_len("len_four_rx", 8, 30);
    tick(5);
    check("len_no_partial", 32'(us_tlength), 32'd8);
    check("ovr_write_drop", 32'(overrun_cnt), 32'(ovr_m));
    us_tready = 1'b1;
    wait_len("drain_four_rx", 0, 40);
    us_tready = 1'b0;

    // fill to 1008 words; 43rd round does not fit (clamped config 16 -> 12)
    set_cfg(6'h00, 4'd15);
    for (int i = 0; i < 43; i++) begin
      send_round(1'b0, i < 42);
      tick(29);
    end
    check("len_full", 32'(us_tlength), 32'd1008);
    check("ovr_full", 32'(overrun_cnt), 32'(ovr_m));

    us_tready = 1'b1;
    tick(24);
    us_tready = 1'b0;
    check("len_after_24", 32'(us_tlength), 32'd984);
    send_round(1'b0, 1'b1);
    tick(30);
    us_tready = 1'b1;
    wait_len("drain_full", 0, 1200);
    us_tready = 1'b0;

    // run low mid-round flushes everything
    send_round(1'b0, 1'b1);
    wait_len("len_five", 5, 30);
    run = 1'b0;
    tick(1);
    check("flush_len", 32'(us_tlength), 32'd0);
    check("flush_valid", 32'(us_tvalid), 32'd0);
    run = 1'b1;
    sb.delete();
    tick(40);
    check("idle_len", 32'(us_tlength), 32'd0);
    us_tready = 1'b1;
    send_round(1'b0, 1'b1);
    tick(4);
    wait_len("drain_after_run", 0, 60);
    us_tready = 1'b0;

    // reset mid-round
    send_round(1'b0, 1'b1);
    tick(6);
    rst_n = 1'b0;
    tick(1);
    check("mid_rst_valid", 32'(us_tvalid), 32'd0);
    check("mid_rst_len", 32'(us_tlength), 32'd0);
    check("mid_rst_out", 32'({us_tuser, us_tlast, us_tdata}), 32'd0);
    check("mid_rst_ovr", 32'(overrun_cnt), 32'd0);
    sb.delete();
    pend_m  = 1'b0;
    ovr_m   = 0;
    cur_nrx = 1;
    rst_n   = 1'b1;
    tick(30);
    check("post_rst_len", 32'(us_tlength), 32'd0);
    us_tready = 1'b1;
    send_round(1'b1, 1'b1);
    tick(3);
    wait_len("drain_post_rst", 0, 20);
    us_tready = 1'b0;
    tick(2);

    check("sb_left", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
